// File: rtl/sa_input_skew_feeder_pkg.sv
// sa_input_skew_feeder shared definitions
// lane slicing helpers, default geometry, FSM states
package sa_input_skew_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PE_SIZE    = 16;
  localparam int DEF_ROWS       = 64;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  // lane 0 sits in the MSBs of a packed word
  function automatic int lane_lsb(
    input int lane,
    input int dw,
    input int pe
  );
    return (pe - 1 - lane) * dw;
  endfunction

endpackage

// File: rtl/sa_input_skew_feeder_delay.sv
// skew_delay_line: per-lane shift register
// DEPTH 0 is a plain wire, hold when en is low
module skew_delay_line
  import sa_input_skew_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en};
    assign dout = din;
  end else begin : g_sr
    logic [WIDTH-1:0] sr_q [DEPTH];

    // shift one slot per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++)
          sr_q[i] <= '0;
      end else if (en) begin
        sr_q[0] <= din;
        for (int i = 1; i < DEPTH; i++)
          sr_q[i] <= sr_q[i-1];
      end
    end

    assign dout = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/sa_input_skew_feeder.sv
// sa_input_skew_feeder: BRAM rows -> skewed lane FIFOs
// lane i lags lane 0 by i cycles, any full lane stalls all
module sa_input_skew_feeder
  import sa_input_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PE_SIZE        = DEF_PE_SIZE,
  parameter int ROWS           = DEF_ROWS,
  parameter int MEM_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [MEM_ADDR_WIDTH-1:0]     base_addr_i,
  output logic                          mem_ce0,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr0,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] mem_q0,
  output logic [PE_SIZE-1:0]            wren_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0] wdata_o,
  input  logic [PE_SIZE-1:0]            full_i,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int W  = DATA_WIDTH * PE_SIZE;
  localparam int RW = $clog2(ROWS + 1);

  feed_state_t state_q, state_d;

  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [RW-1:0]             rd_cnt_q;
  logic [RW-1:0]             wr_cnt_q;
  logic                      rd_pend_q;
  logic                      hold_v_q;
  logic [W-1:0]              hold_q;
  logic [W-1:0]              s0_q;
  logic [PE_SIZE-1:0]        vld_q;
  logic                      done_q;

  logic         stall;
  logic         adv;
  logic         accept;
  logic         last_rd;
  logic         last_wr;
  logic         in_v;
  logic [W-1:0] in_data;

  assign stall  = |full_i;
  assign adv    = ~stall;
  assign accept = start_i && (state_q == IDLE) && !done_q;

  assign mem_ce0   = (state_q == READ) && adv;
  assign mem_addr0 = base_q + MEM_ADDR_WIDTH'(rd_cnt_q);

  assign last_rd = (rd_cnt_q == RW'(ROWS - 1));
  assign last_wr = wren_o[PE_SIZE-1]
                && (wr_cnt_q == RW'(ROWS - 1));

  // a parked word always wins: no read can be in flight with it
  assign in_v    = rd_pend_q | hold_v_q;
  assign in_data = hold_v_q ? hold_q : mem_q0;

  assign wren_o = adv ? vld_q : '0;
  assign busy_o = (state_q != IDLE) || done_q;
  assign done_o = done_q;

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (mem_ce0 && last_rd) state_d = DRAIN;
      DRAIN:   if (last_wr) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control state, counters and read tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= (state_q == DONE);
      rd_pend_q <= mem_ce0;
      if (accept) begin
        base_q   <= base_addr_i;
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
      end else begin
        if (mem_ce0)
          rd_cnt_q <= rd_cnt_q + RW'(1);
        if (wren_o[PE_SIZE-1])
          wr_cnt_q <= wr_cnt_q + RW'(1);
      end
    end
  end

  // park a word that lands while the lanes are stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else if (adv) begin
      hold_v_q <= 1'b0;
    end else if (rd_pend_q) begin
      hold_v_q <= 1'b1;
      hold_q   <= mem_q0;
    end
  end

  // stage 0 word register and skew valid chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q  <= '0;
      vld_q <= '0;
    end else if (adv) begin
      if (in_v)
        s0_q <= in_data;
      vld_q <= {vld_q[PE_SIZE-2:0], in_v};
    end
  end

  for (genvar g = 0; g < PE_SIZE; g++) begin : g_lane
    localparam int LSB = lane_lsb(g, DATA_WIDTH, PE_SIZE);

    skew_delay_line #(
      .DEPTH (g),
      .WIDTH (DATA_WIDTH)
    ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .din   (s0_q[LSB +: DATA_WIDTH]),
      .dout  (wdata_o[LSB +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_sa_input_skew_feeder.sv
// tb_sa_input_skew_feeder: timing tables plus lane scoreboard
// PE_SIZE=4, ROWS=4, 3-bit addresses so wrap is reachable
module tb_sa_input_skew_feeder;

  localparam int DW   = 8;
  localparam int PE   = 4;
  localparam int ROWS = 4;
  localparam int AW   = 3;
  localparam int W    = DW * PE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic          mem_ce0;
  logic [AW-1:0] mem_addr0;
  logic [W-1:0]  mem_q0 = '0;
  logic [PE-1:0] wren_o;
  logic [W-1:0]  wdata_o;
  logic [PE-1:0] full_i = '0;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sbq [PE][$];

  typedef struct {
    logic          start;
    logic [PE-1:0] full;
    logic          ce;
    logic [AW-1:0] addr;
    logic [PE-1:0] wren;
    logic          done;
    logic          busy;
  } vec_t;

  vec_t basic[$];
  vec_t stl[$];

  always #5 clk = ~clk;

  sa_input_skew_feeder #(
    .DATA_WIDTH     (DW),
    .PE_SIZE        (PE),
    .ROWS           (ROWS),
    .MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .mem_ce0     (mem_ce0),
    .mem_addr0   (mem_addr0),
    .mem_q0      (mem_q0),
    .wren_o      (wren_o),
    .wdata_o     (wdata_o),
    .full_i      (full_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  function automatic logic [W-1:0] mem_word(input int a);
    logic [W-1:0] r;
    for (int i = 0; i < PE; i++)
      r[W-1-i*DW -: DW] = DW'(a + 16 * i);
    return r;
  endfunction

  // BRAM model: one-cycle read, garbage when not enabled
  always @(posedge clk) begin
    if (mem_ce0)
      mem_q0 <= mem_word(int'(mem_addr0));
    else
      mem_q0 <= W'($urandom);
  end

  // lane scoreboard: every write must match the next queued byte
  always @(negedge clk) begin
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    if (rst_n) begin
      for (int i = 0; i < PE; i++) begin
        if (wren_o[i]) begin
          got = wdata_o[W-1-i*DW -: DW];
          checks++;
          if (sbq[i].size() == 0) begin
            errors++;
            $display("FAIL lane%0d_data got %0h expected no write",
                     i, got);
          end else begin
            exp = sbq[i].pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL lane%0d_data got %0h expected %0h",
                       i, got, exp);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_run(input int base);
    logic [W-1:0] w;
    for (int k = 0; k < ROWS; k++) begin
      w = mem_word((base + k) % (1 << AW));
      for (int i = 0; i < PE; i++)
        sbq[i].push_back(w[W-1-i*DW -: DW]);
    end
  endtask

  task automatic flush_sb();
    for (int i = 0; i < PE; i++)
      sbq[i].delete();
  endtask

  task automatic check_drained(input string tag);
    for (int i = 0; i < PE; i++)
      chk($sformatf("%s_lane%0d_left", tag, i), sbq[i].size(), 0);
  endtask

  task automatic step(input logic s, input logic [PE-1:0] f);
    @(posedge clk);
    #1;
    start_i = s;
    full_i  = f;
    @(negedge clk);
  endtask

  task automatic wait_done(input int first, input int max,
                           output int dc);
    dc = -1;
    for (int n = 0; n < max; n++) begin
      step(1'b0, '0);
      if (done_o) begin
        dc = first + n;
        break;
      end
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag,
                           input int c);
    step(v.start, v.full);
    chk($sformatf("%s_c%0d_ce", tag, c), 32'(mem_ce0), 32'(v.ce));
    if (v.ce)
      chk($sformatf("%s_c%0d_addr", tag, c),
          32'(mem_addr0), 32'(v.addr));
    chk($sformatf("%s_c%0d_wren", tag, c), 32'(wren_o), 32'(v.wren));
    chk($sformatf("%s_c%0d_done", tag, c), 32'(done_o), 32'(v.done));
    chk($sformatf("%s_c%0d_busy", tag, c), 32'(busy_o), 32'(v.busy));
    if (v.start)
      push_run(int'(base_addr_i));
  endtask

  function automatic vec_t mk(input logic s, input logic [PE-1:0] f,
                              input logic ce, input int a,
                              input logic [PE-1:0] wr,
                              input logic d, input logic b);
    vec_t v;
    v.start = s;
    v.full  = f;
    v.ce    = ce;
    v.addr  = AW'(a);
    v.wren  = wr;
    v.done  = d;
    v.busy  = b;
    return v;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc;
    int n;
    logic [AW-1:0] wexp [4];

    // unstalled run, base 0: done lands at cycle 11
    basic.push_back(mk(1, 4'h0, 0, 0, 4'b0000, 0, 0));
    basic.push_back(mk(0, 4'h0, 1, 0, 4'b0000, 0, 1));
    basic.push_back(mk(0, 4'h0, 1, 1, 4'b0000, 0, 1));
    basic.push_back(mk(0, 4'h0, 1, 2, 4'b0001, 0, 1));
    basic.push_back(mk(0, 4'h0, 1, 3, 4'b0011, 0, 1));
    basic.push_back(mk(0, 4'h0, 0, 0, 4'b0111, 0, 1));
    basic.push_back(mk(0, 4'h0, 0, 0, 4'b1111, 0, 1));
    basic.push_back(mk(0, 4'h0, 0, 0, 4'b1110, 0, 1));
    basic.push_back(mk(0, 4'h0, 0, 0, 4'b1100, 0, 1));
    basic.push_back(mk(0, 4'h0, 0, 0, 4'b1000, 0, 1));
    basic.push_back(mk(0, 4'h0, 0, 0, 4'b0000, 0, 1));
    basic.push_back(mk(0, 4'h0, 0, 0, 4'b0000, 1, 1));
    basic.push_back(mk(0, 4'h0, 0, 0, 4'b0000, 0, 0));

    // lane 2 full in cycles 5..7, row 3 returns into the stall
    stl.push_back(mk(1, 4'h0, 0, 0, 4'b0000, 0, 0));
    stl.push_back(mk(0, 4'h0, 1, 0, 4'b0000, 0, 1));
    stl.push_back(mk(0, 4'h0, 1, 1, 4'b0000, 0, 1));
    stl.push_back(mk(0, 4'h0, 1, 2, 4'b0001, 0, 1));
    stl.push_back(mk(0, 4'h0, 1, 3, 4'b0011, 0, 1));
    stl.push_back(mk(0, 4'h4, 0, 0, 4'b0000, 0, 1));
    stl.push_back(mk(0, 4'h4, 0, 0, 4'b0000, 0, 1));
    stl.push_back(mk(0, 4'h4, 0, 0, 4'b0000, 0, 1));
    stl.push_back(mk(0, 4'h0, 0, 0, 4'b0111, 0, 1));
    stl.push_back(mk(0, 4'h0, 0, 0, 4'b1111, 0, 1));
    stl.push_back(mk(0, 4'h0, 0, 0, 4'b1110, 0, 1));
    stl.push_back(mk(0, 4'h0, 0, 0, 4'b1100, 0, 1));
    stl.push_back(mk(0, 4'h0, 0, 0, 4'b1000, 0, 1));
    stl.push_back(mk(0, 4'h0, 0, 0, 4'b0000, 0, 1));
    stl.push_back(mk(0, 4'h0, 0, 0, 4'b0000, 1, 1));
    stl.push_back(mk(0, 4'h0, 0, 0, 4'b0000, 0, 0));

    wexp[0] = 3'd6;
    wexp[1] = 3'd7;
    wexp[2] = 3'd0;
    wexp[3] = 3'd1;

    // reset state
    #12;
    chk("rst_ce", 32'(mem_ce0), 0);
    chk("rst_addr", 32'(mem_addr0), 0);
    chk("rst_wren", 32'(wren_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, '0);

    base_addr_i = '0;
    for (int c = 0; c < basic.size(); c++)
      apply_vec(basic[c], "basic", c);
    check_drained("basic");
    step(0, '0);

    for (int c = 0; c < stl.size(); c++)
      apply_vec(stl[c], "stall", c);
    check_drained("stall");
    step(0, '0);

    // address wrap: base 6 reads 6,7,0,1
    base_addr_i = 3'd6;
    step(1, '0);
    push_run(6);
    n = 0;
    for (int c = 1; c <= 6; c++) begin
      step(0, '0);
      if (mem_ce0) begin
        if (n < 4)
          chk($sformatf("wrap_addr%0d", n), 32'(mem_addr0),
              32'(wexp[n]));
        n++;
      end
    end
    chk("wrap_reads", n, 4);
    wait_done(7, 30, dc);
    chk("wrap_done_cycle", dc, 11);
    check_drained("wrap");
    step(0, '0);

    // stall in the cycle the first word returns
    base_addr_i = 3'd2;
    step(1, '0);
    push_run(2);
    step(0, '0);
    step(0, 4'b1000);
    chk("ret_stall_ce", 32'(mem_ce0), 0);
    chk("ret_stall_wren", 32'(wren_o), 0);
    wait_done(3, 30, dc);
    chk("ret_stall_done_cycle", dc, 12);
    check_drained("ret_stall");
    step(0, '0);

    // start while busy and in the done cycle is ignored
    base_addr_i = 3'd0;
    step(1, '0);
    push_run(0);
    for (int c = 1; c <= 4; c++)
      step(0, '0);
    step(1, '0);
    step(0, '0);
    chk("busy_start_ce_c6", 32'(mem_ce0), 0);
    for (int c = 7; c <= 10; c++)
      step(0, '0);
    base_addr_i = 3'd5;
    step(1, '0);
    chk("ign_done_c11", 32'(done_o), 1);
    step(1, '0);
    chk("ign_ce_c12", 32'(mem_ce0), 0);
    chk("ign_busy_c12", 32'(busy_o), 0);
    push_run(5);
    step(0, '0);
    chk("restart_ce", 32'(mem_ce0), 1);
    chk("restart_addr", 32'(mem_addr0), 5);
    wait_done(14, 30, dc);
    chk("restart_done_cycle", dc, 23);
    check_drained("restart");
    step(0, '0);

    // reset in the middle of READ
    base_addr_i = 3'd0;
    step(1, '0);
    push_run(0);
    for (int c = 1; c <= 3; c++)
      step(0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ce", 32'(mem_ce0), 0);
    chk("mid_rst_addr", 32'(mem_addr0), 0);
    chk("mid_rst_wren", 32'(wren_o), 0);
    chk("mid_rst_wdata", wdata_o, 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    flush_sb();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, '0);
    base_addr_i = 3'd3;
    step(1, '0);
    push_run(3);
    wait_done(1, 30, dc);
    chk("post_rst_done_cycle", dc, 11);
    check_drained("post_rst");
    step(0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
